// File: rtl/caravel_io_pkg.sv
// caravel_io_pkg: shared types and helpers for the Caravel IO adapter.
//   adapter_state_e : bring-up FSM encoding (WAIT_READY / HOLD / RUN)
//   cnt_width()     : bit width needed to hold values 0..max_val
package caravel_io_pkg;

  typedef enum logic [1:0] {
    WAIT_READY = 2'd0,
    HOLD       = 2'd1,
    RUN        = 2'd2
  } adapter_state_e;

  function automatic int cnt_width(input int max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/io_debounce.sv
// io_debounce: one button channel.
//   2-FF synchroniser on the raw active-low pad, stable-count debouncer,
//   registered press pulse that is only allowed when the core is in RUN.
//   Optional auto-repeat under `ADAPTER_AUTOREPEAT_EN.
// Ports:
//   clk, rst_n  : clock, async active-low reset
//   btn_n       : raw pad, active-low, asynchronous
//   run         : FSM is in RUN this cycle
//   run_next    : FSM will be in RUN after the coming edge
//   level       : debounced pressed state (active-high)
//   press       : one-cycle pulse per accepted press (plus repeats)
module io_debounce
  import caravel_io_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int REPEAT_DELAY    = 256,
  parameter int REPEAT_PERIOD   = 64
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_n,
  input  logic run,
  input  logic run_next,
  output logic level,
  output logic press
);

  localparam int DW = cnt_width(DEBOUNCE_CYCLES);

  logic          sync1, sync2;
  logic [DW-1:0] db_cnt;
  logic          raw, accept, level_d, rose;

  // Pads idle high, so the synchroniser resets to "released".
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= 1'b1;
      sync2 <= 1'b1;
    end else begin
      sync1 <= btn_n;
      sync2 <= sync1;
    end
  end

  assign raw     = ~sync2;
  // Accept on the DEBOUNCE_CYCLES-th consecutive differing cycle; the count
  // never exceeds DEBOUNCE_CYCLES-1 so it cannot wrap.
  assign accept  = (raw != level) && (db_cnt == DW'(DEBOUNCE_CYCLES - 1));
  assign level_d = accept ? raw : level;
  assign rose    = accept & raw;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      level  <= 1'b0;
      db_cnt <= '0;
    end else begin
      level <= level_d;
      if (raw == level || accept) db_cnt <= '0;
      else                        db_cnt <= db_cnt + 1'b1;
    end
  end

`ifdef ADAPTER_AUTOREPEAT_EN
  localparam int RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int RW   = cnt_width(RMAX);

  logic [RW-1:0] rep_cnt;
  logic          rep_first, act_cur, act_next, rep_hit;

  // A repeat window is "held and in RUN"; it restarts whenever it is entered.
  assign act_cur  = level & run;
  assign act_next = level_d & run_next;
  assign rep_hit  = act_cur & act_next &
                    ((rep_cnt + 1'b1) == (rep_first ? RW'(REPEAT_DELAY) : RW'(REPEAT_PERIOD)));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rep_cnt   <= '0;
      rep_first <= 1'b1;
      press     <= 1'b0;
    end else begin
      press <= (rose & run_next) | rep_hit;
      if (!act_cur || !act_next) begin
        rep_cnt   <= '0;
        rep_first <= 1'b1;
      end else if (rep_hit) begin
        rep_cnt   <= '0;
        rep_first <= 1'b0;
      end else begin
        rep_cnt <= rep_cnt + 1'b1;
      end
    end
  end
`else
  localparam int unused_rep = REPEAT_DELAY + REPEAT_PERIOD;
  logic unused_run;
  assign unused_run = run;

  // Gated on the post-edge state so a press coinciding with leaving RUN is dropped.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) press <= 1'b0;
    else        press <= rose & run_next;
  end
`endif

endmodule

// File: rtl/caravel_io_adapter.sv
// caravel_io_adapter: glue between Caravel pads/LA and a game core.
//   Debounces NUM_INPUTS active-low buttons, sequences core reset from the
//   LA gpio_ready handshake and the ext_reset_n pad, and holds output
//   enables off until the GPIO configuration is ready.
//   Optional per-button auto-repeat: define ADAPTER_AUTOREPEAT_EN.
// Ports:
//   wb_clk_i, reset_n        : clock, async active-low reset
//   gpio_ready, ext_reset_n  : async control inputs (synchronised here)
//   btn_n                    : raw active-low button pads
//   btn_level, btn_press     : debounced level / press pulses
//   design_reset, design_oeb : core reset (active-high) and pad oeb
//   debug_design_reset       : copy of design_reset
//   debug_gpio_ready         : synchronised gpio_ready
module caravel_io_adapter
  import caravel_io_pkg::*;
#(
  parameter int NUM_INPUTS        = 5,
  parameter int NUM_OUTPUTS       = 8,
  parameter int DEBOUNCE_CYCLES   = 16,
  parameter int RESET_HOLD_CYCLES = 8,
  parameter int REPEAT_DELAY      = 256,
  parameter int REPEAT_PERIOD     = 64
) (
  input  logic                   wb_clk_i,
  input  logic                   reset_n,
  input  logic                   gpio_ready,
  input  logic                   ext_reset_n,
  input  logic [NUM_INPUTS-1:0]  btn_n,
  output logic [NUM_INPUTS-1:0]  btn_level,
  output logic [NUM_INPUTS-1:0]  btn_press,
  output logic                   design_reset,
  output logic [NUM_OUTPUTS-1:0] design_oeb,
  output logic                   debug_design_reset,
  output logic                   debug_gpio_ready
);

  localparam int HW = cnt_width(RESET_HOLD_CYCLES);

  logic           gpio_s1, gpio_s, ext_s1, ext_s;
  adapter_state_e state, state_d;
  logic [HW-1:0]  hold_cnt, hold_d;
  logic           run_now, run_next;

  // Both controls reset to the "not ready / in reset" side.
  always_ff @(posedge wb_clk_i or negedge reset_n) begin
    if (!reset_n) begin
      gpio_s1 <= 1'b0;
      gpio_s  <= 1'b0;
      ext_s1  <= 1'b0;
      ext_s   <= 1'b0;
    end else begin
      gpio_s1 <= gpio_ready;
      gpio_s  <= gpio_s1;
      ext_s1  <= ext_reset_n;
      ext_s   <= ext_s1;
    end
  end

  always_ff @(posedge wb_clk_i or negedge reset_n) begin
    if (!reset_n) begin
      state    <= WAIT_READY;
      hold_cnt <= '0;
    end else begin
      state    <= state_d;
      hold_cnt <= hold_d;
    end
  end

  // hold_cnt counts consecutive ext_s-high cycles in HOLD; it tops out at
  // RESET_HOLD_CYCLES-1 because that is where we leave for RUN.
  always_comb begin
    state_d = state;
    hold_d  = hold_cnt;
    if (!gpio_s) begin
      state_d = WAIT_READY;
    end else begin
      case (state)
        WAIT_READY: begin
          state_d = HOLD;
          hold_d  = '0;
        end
        HOLD: begin
          if (!ext_s)                                         hold_d  = '0;
          else if (hold_cnt == HW'(RESET_HOLD_CYCLES - 1))   state_d = RUN;
          else                                                hold_d  = hold_cnt + 1'b1;
        end
        RUN: begin
          if (!ext_s) begin
            state_d = HOLD;
            hold_d  = '0;
          end
        end
        default: state_d = WAIT_READY;
      endcase
    end
  end

  assign run_now            = (state == RUN);
  assign run_next           = (state_d == RUN);
  assign design_reset       = ~run_now;
  assign debug_design_reset = ~run_now;
  assign design_oeb         = (state == WAIT_READY) ? {NUM_OUTPUTS{1'b1}} : {NUM_OUTPUTS{1'b0}};
  assign debug_gpio_ready   = gpio_s;

  for (genvar i = 0; i < NUM_INPUTS; i++) begin : g_ch
    io_debounce #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .REPEAT_DELAY    (REPEAT_DELAY),
      .REPEAT_PERIOD   (REPEAT_PERIOD)
    ) u_ch (
      .clk      (wb_clk_i),
      .rst_n    (reset_n),
      .btn_n    (btn_n[i]),
      .run      (run_now),
      .run_next (run_next),
      .level    (btn_level[i]),
      .press    (btn_press[i])
    );
  end

endmodule

// File: tb/tb_caravel_io_adapter.sv
// Scoreboard bench: a per-cycle behavioural model (windowed stability test for
// debounce, run-length rule for reset hold) pushes expected outputs into a
// queue; a negedge monitor pops and compares against the DUT.
module tb_caravel_io_adapter;
  localparam int NI = 5, NO = 8, DB = 8, RH = 4, RD = 20, RP = 5, MAXC = 8192;

  logic          clk = 1'b0, reset_n = 1'b0, gpio_ready = 1'b0, ext_reset_n = 1'b0;
  logic [NI-1:0] btn_n = '1;
  logic [NI-1:0] btn_level, btn_press;
  logic          design_reset, debug_design_reset, debug_gpio_ready;
  logic [NO-1:0] design_oeb;

  caravel_io_adapter #(
    .NUM_INPUTS(NI), .NUM_OUTPUTS(NO), .DEBOUNCE_CYCLES(DB),
    .RESET_HOLD_CYCLES(RH), .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP)
  ) dut (
    .wb_clk_i(clk), .reset_n(reset_n), .gpio_ready(gpio_ready), .ext_reset_n(ext_reset_n),
    .btn_n(btn_n), .btn_level(btn_level), .btn_press(btn_press),
    .design_reset(design_reset), .design_oeb(design_oeb),
    .debug_design_reset(debug_design_reset), .debug_gpio_ready(debug_gpio_ready)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [NI-1:0] level;
    logic [NI-1:0] press;
    logic          dres;
    logic [NO-1:0] oeb;
    logic          gpio;
  } exp_t;

  exp_t sbq[$];
  int   total = 0, bad = 0;

  // input history, index = cycle number since reset release
  logic [NI-1:0] h_btn  [0:MAXC-1];
  logic          h_gpio [0:MAXC-1];
  logic          h_ext  [0:MAXC-1];
  int            cyc = 0;

  typedef enum int {M_WAIT, M_HOLD, M_RUN} mst_t;
  mst_t          m_st;
  int            m_streak;
  logic [NI-1:0] m_lvl;
  bit            m_act   [NI];
  int            m_start [NI];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // value seen by the core side in cycle x (two-flop delay, reset defaults before 0)
  function automatic logic raw_at(int x, int i);
    if (x - 2 < 0) return 1'b0;
    return ~h_btn[x-2][i];
  endfunction
  function automatic logic gs_at(int x);
    if (x - 2 < 0) return 1'b0;
    return h_gpio[x-2];
  endfunction
  function automatic logic es_at(int x);
    if (x - 2 < 0) return 1'b0;
    return h_ext[x-2];
  endfunction

  task automatic model_reset();
    m_st = M_WAIT; m_streak = 0; m_lvl = '0;
    for (int i = 0; i < NI; i++) begin m_act[i] = 0; m_start[i] = 0; end
  endtask

  task automatic model_step(input int c);
    mst_t nst;
    exp_t e;
    // RUN is reached once HOLD has seen ext high for RH straight cycles
    if (m_st == M_HOLD && es_at(c - 1)) m_streak++;
    else                                m_streak = 0;
    if (!gs_at(c - 1)) nst = M_WAIT;
    else case (m_st)
      M_WAIT:  nst = M_HOLD;
      M_HOLD:  nst = (m_streak >= RH) ? M_RUN : M_HOLD;
      default: nst = es_at(c - 1) ? M_RUN : M_HOLD;
    endcase
    for (int i = 0; i < NI; i++) begin
      bit flip = 1;
      bit pr;
      // level flips once the last DB raw samples all disagree with it
      for (int k = 1; k <= DB; k++) if (raw_at(c - k, i) == m_lvl[i]) flip = 0;
      e.level[i] = flip ? ~m_lvl[i] : m_lvl[i];
      pr = flip && e.level[i] && (nst == M_RUN);
`ifdef ADAPTER_AUTOREPEAT_EN
      if (e.level[i] && nst == M_RUN) begin
        if (!m_act[i]) begin m_act[i] = 1; m_start[i] = c; end
        else if ((c - m_start[i]) >= RD && ((c - m_start[i] - RD) % RP) == 0) pr = 1;
      end else m_act[i] = 0;
`endif
      e.press[i] = pr;
    end
    e.dres = (nst != M_RUN);
    e.oeb  = (nst == M_WAIT) ? {NO{1'b1}} : {NO{1'b0}};
    e.gpio = gs_at(c);
    sbq.push_back(e);
    m_st  = nst;
    m_lvl = e.level;
  endtask

  // record this cycle's inputs, advance one edge, model it, then free inputs
  task automatic step(input int n);
    for (int j = 0; j < n; j++) begin
      h_btn[cyc] = btn_n; h_gpio[cyc] = gpio_ready; h_ext[cyc] = ext_reset_n;
      @(posedge clk);
      cyc++;
      model_step(cyc);
      #1;
    end
  endtask

  always @(negedge clk) begin
    if (sbq.size() > 0) begin
      exp_t e;
      e = sbq.pop_front();
      chk("btn_level", 32'(btn_level), 32'(e.level));
      chk("btn_press", 32'(btn_press), 32'(e.press));
      chk("design_reset", 32'(design_reset), 32'(e.dres));
      chk("debug_design_reset", 32'(debug_design_reset), 32'(e.dres));
      chk("design_oeb", 32'(design_oeb), 32'(e.oeb));
      chk("debug_gpio_ready", 32'(debug_gpio_ready), 32'(e.gpio));
    end
  end

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_level"}, 32'(btn_level), 32'd0);
    chk({tag, "_press"}, 32'(btn_press), 32'd0);
    chk({tag, "_dres"}, 32'(design_reset), 32'd1);
    chk({tag, "_dbgres"}, 32'(debug_design_reset), 32'd1);
    chk({tag, "_oeb"}, 32'(design_oeb), 32'hFF);
    chk({tag, "_gpio"}, 32'(debug_gpio_ready), 32'd0);
  endtask

  task automatic release_reset();
    @(posedge clk); #1;
    reset_n = 1'b1;
    cyc = 0;
    model_reset();
  endtask

  int ext_lo = 0, gpio_lo = 0;

  initial begin
    // reset with arbitrary pads
    btn_n = NI'($urandom); gpio_ready = 1'($urandom); ext_reset_n = 1'($urandom);
    #12;
    check_reset_outputs("reset");
    btn_n = '1; gpio_ready = 1'b0; ext_reset_n = 1'b1;
    release_reset();

    // bring-up
    step(3);
    gpio_ready = 1'b1;
    step(12);

    // bounce on button 2, then a clean press and release
    repeat (4) begin
      btn_n[2] = 1'b0; step(3);
      btn_n[2] = 1'b1; step(2);
    end
    btn_n[2] = 1'b0; step(20);
    btn_n[2] = 1'b1; step(20);

    // gpio_ready drop in RUN; presses must not pulse
    gpio_ready = 1'b0; step(2);
    btn_n[0] = 1'b0; step(15);
    btn_n[0] = 1'b1; gpio_ready = 1'b1; step(25);

    // ext reset glitch in RUN, second glitch mid-HOLD
    ext_reset_n = 1'b0; step(1);
    ext_reset_n = 1'b1; step(2);
    ext_reset_n = 1'b0; step(1);
    ext_reset_n = 1'b1; step(12);

    // long hold (exercises auto-repeat when enabled)
    btn_n[1] = 1'b0; step(60);
    btn_n[1] = 1'b1; step(20);

    // randomized traffic
    for (int t = 0; t < 1500; t++) begin
      for (int i = 0; i < NI; i++) if ($urandom_range(0, 9) == 0) btn_n[i] = ~btn_n[i];
      if (ext_lo > 0) begin ext_lo--; ext_reset_n = (ext_lo == 0); end
      else if ($urandom_range(0, 59) == 0) begin ext_lo = $urandom_range(1, 3); ext_reset_n = 1'b0; end
      if (gpio_lo > 0) begin gpio_lo--; gpio_ready = (gpio_lo == 0); end
      else if ($urandom_range(0, 299) == 0) begin gpio_lo = $urandom_range(1, 8); gpio_ready = 1'b0; end
      step(1);
    end

    // async reset mid-operation, after this cycle's entry is consumed
    btn_n = '0; gpio_ready = 1'b1; ext_reset_n = 1'b1; step(30);
    @(negedge clk); #1;
    reset_n = 1'b0;
    #1;
    check_reset_outputs("midreset");
    repeat (2) @(posedge clk);
    btn_n = '1;
    release_reset();
    step(15);
    btn_n[4] = 1'b0; step(15);
    btn_n[4] = 1'b1; step(15);

    repeat (3) @(negedge clk);
    #1;
    chk("scoreboard_drained", 32'(sbq.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // absolute time bound
  initial begin
    #500000;
    $display("FAIL timeout: simulation did not finish (cycle %0d)", cyc);
    $fatal(1);
  end
endmodule

// File: doc/caravel_io_adapter.md
Name: caravel_io_adapter

Overview:
Parametrised successor to the fixed per-design Caravel adapter logic. Sits between the Caravel pads/LA and a game core (solo_squash and successors). Synchronises and debounces N active-low button pads into clean levels and press pulses. Sequences core bring-up from the LA gpio_ready handshake and the external reset pad, and gates output-enables until the GPIO configuration is known good.

Parameters:
NUM_INPUTS, 5, number of active-low button pads (>=1)
NUM_OUTPUTS, 8, number of core output pads whose oeb this block drives (>=1)
DEBOUNCE_CYCLES, 16, consecutive stable cycles required to accept a button change (>=1)
RESET_HOLD_CYCLES, 8, minimum cycles the core is held in reset with outputs driven (>=1)
REPEAT_DELAY, 256, cycles held before first auto-repeat (ADAPTER_AUTOREPEAT_EN only)
REPEAT_PERIOD, 64, cycles between auto-repeats (ADAPTER_AUTOREPEAT_EN only)

Ports:
wb_clk_i  in  1  sole clock
reset_n  in  1  asynchronous active-low reset, all flops
gpio_ready  in  1  LA bit from management CPU; 1 = GPIO config complete (async)
ext_reset_n  in  1  raw pad, active-low core reset request (async)
btn_n  in  NUM_INPUTS  raw button pads, active-low (async)
btn_level  out  NUM_INPUTS  debounced pressed state, active-high
btn_press  out  NUM_INPUTS  one-cycle pulse per accepted press
design_reset  out  1  active-high reset to core
design_oeb  out  NUM_OUTPUTS  oeb for core output pads
debug_design_reset  out  1  copy of design_reset
debug_gpio_ready  out  1  synchronised gpio_ready loopback

Behaviour:
- Reset values: btn_level=0, btn_press=0, design_reset=1, design_oeb=all 1, debug_design_reset=1, debug_gpio_ready=0, FSM=WAIT_READY.
- Sync: gpio_ready, ext_reset_n and each btn_n pass through 2-FF synchronisers. Reset values: btn 1 (released), gpio_ready 0, ext_reset_n 0.
- Debounce (per channel): raw = ~btn_sync. Counter increments while raw != btn_level and clears on any cycle raw == btn_level. When the count reaches DEBOUNCE_CYCLES, btn_level <= raw and the counter clears. Pad-to-btn_level latency = 2 + DEBOUNCE_CYCLES cycles. Bounces shorter than DEBOUNCE_CYCLES are never visible.
- btn_press: registered. Asserts for exactly one cycle, coincident with btn_level 0->1. Forced 0 unless FSM=RUN. Debouncing continues in all states.
- FSM, states WAIT_READY, HOLD, RUN. Outputs decode from the state register only:
  - WAIT_READY: design_reset=1, oeb all 1. If gpio_s=1, go to HOLD and clear hold_cnt.
  - HOLD: design_reset=1, oeb all 0. If ext_s=0, clear hold_cnt and stay. Otherwise increment hold_cnt; when hold_cnt==RESET_HOLD_CYCLES-1 and ext_s=1, go to RUN. Hold time is therefore exactly RESET_HOLD_CYCLES cycles after ext_s is last seen high continuously.
  - RUN: design_reset=0, oeb all 0. If ext_s=0, go to HOLD and clear hold_cnt.
  - gpio_s=0 in any state: go to WAIT_READY. This has priority over every other transition.
- Simultaneous press and FSM leaving RUN: press suppressed. Async reset mid-operation returns all outputs to reset values immediately.
- hold_cnt width $clog2(RESET_HOLD_CYCLES+1). Debounce counter width $clog2(DEBOUNCE_CYCLES+1). Counters saturate and never wrap.

Optional Feature:
ADAPTER_AUTOREPEAT_EN
- Defined: per channel, while btn_level=1 in RUN, a repeat counter runs. The first extra btn_press occurs REPEAT_DELAY cycles after the accepted press, then one every REPEAT_PERIOD cycles. The counter clears on release or when leaving RUN.
- Undefined: exactly one btn_press per accepted press; no repeat logic or parameters are used.

Decomposition:
- Package caravel_io_pkg: FSM state typedef (WAIT_READY=2'd0, HOLD=2'd1, RUN=2'd2) and a clog2-based width helper constant function.
- Sub-module io_debounce: one channel containing the sync, counter, level, press pulse and optional repeat logic. Instantiated NUM_INPUTS times via generate. The FSM lives in the top module.

Test Plan:
- Reset: reset_n=0 with arbitrary pads -> design_reset=1, design_oeb=8'hFF, btn_level=0, btn_press=0, debug_gpio_ready=0.
- Bring-up, RESET_HOLD_CYCLES=4, ext_reset_n=1: gpio_ready 0->1 at cycle 0 -> HOLD at cycle 3 (oeb=0, design_reset=1); design_reset=0 from cycle 7.
- Debounce, DEBOUNCE_CYCLES=8, RUN: btn_n[2] bounces low 3 cycles / high 2 cycles, 4 times -> no btn_level/btn_press change. Then steady low -> btn_level[2]=1 exactly 10 cycles after the final low edge, with a single btn_press[2] pulse. Release 8+2 cycles -> btn_level[2]=0 with no pulse.
- gpio_ready drop in RUN -> within 3 cycles FSM=WAIT_READY, design_oeb all 1, design_reset=1, press on any button yields no btn_press.
- ext_reset_n low 1 cycle in RUN -> HOLD. Full RESET_HOLD_CYCLES re-count after ext_s returns high; second glitch mid-HOLD restarts the count from 0.
- With ADAPTER_AUTOREPEAT_EN, REPEAT_DELAY=20, REPEAT_PERIOD=5: hold button 40 cycles after acceptance -> pulses at +0, +20, +25, +30, +35, +40. Release -> no further pulses.
